servo_pulse_decoder: RTL and testbench
======================================

Name: servo_pulse_decoder

Overview:
- Receive-side counterpart of the servo PWM generator: measures an incoming servo pulse train and returns the high time in microseconds.
- Output uses the same 16-bit units as the generator's load data, so a decoded value can be written straight back to a generator.
- Used for loopback checking of servo outputs and for reading external RC receiver channels into the host register map.

Parameters:
- CLKS_PER_US, 100, clk cycles per microsecond; 100 MHz clk.
- MIN_PULSE_US, 500, shortest accepted high time in us.
- MAX_PULSE_US, 2500, longest accepted high time in us.
- TIMEOUT_US, 25000, maximum us from a rising edge to the next event before declaring signal loss.
- FILTER_CYCLES, 8, stability requirement in cycles; used only with GLITCH_FILTER_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- signal_in  input  1  asynchronous servo pulse input.
- data  output  16  last accepted high time in us.
- valid  output  1  one-cycle strobe when data updates.
- period  output  16  last measured rising-to-rising interval in us, saturating.
- error  output  1  one-cycle strobe when a pulse is rejected for being out of range.
- timeout  output  1  sticky signal-loss flag.

Behaviour:
- Reset (rst==0 at posedge): data=0, valid=0, period=0, error=0, timeout=0; all counters 0; state ARM.
- Input path:
  - Two-flop synchronizer, then one edge register.
  - rise/fall are detected 3 clk after the pin transition.
  - All timing below is relative to detect cycles.
- Timebase:
  - Prescaler counts 0..CLKS_PER_US-1 and is forced to 0 on each rise detect.
  - At terminal count, hi_us increments (in HIGH) and el_us increments (in HIGH and LOW).
  - Both are 16-bit and saturate at 16'hFFFF, with no wrap.
  - Result is floor(cycles/CLKS_PER_US); exactly N*CLKS_PER_US cycles high measures N.
- States:
  - ARM: wait for synchronized level 0, then go to WAIT_RISE. A pulse in progress at reset is discarded.
  - WAIT_RISE: on rise, clear hi_us and el_us, clear prescaler, go to HIGH. No timeout in this state; first edge after reset never reports period.
  - HIGH: on fall, go to LOW.
    - If MIN_PULSE_US <= hi_us <= MAX_PULSE_US: data<=hi_us, valid=1 for one cycle, timeout<=0.
    - Otherwise: error=1 for one cycle; data and timeout unchanged.
  - LOW: on rise, period<=el_us; clear hi_us, el_us and prescaler; go to HIGH.
- Timeout:
  - In HIGH or LOW, when el_us reaches TIMEOUT_US with no edge: timeout<=1.
  - From HIGH, go to ARM (stuck high); from LOW, go to WAIT_RISE.
  - period and data hold.
  - If an edge and the timeout condition occur in the same cycle, the edge wins.
- valid and error are never both 1. Both are 0 in every cycle not listed above.
- Outputs are registered; data/period change only in the cycle valid or period update occurs.
- Reset asserted mid-pulse: immediate return to reset values next posedge, no strobe emitted.

Optional Feature:
- Macro: GLITCH_FILTER_EN.
- Defined:
  - A filter stage sits between the synchronizer and the edge register.
  - The filtered level changes only after the synchronized input has held the new value for FILTER_CYCLES consecutive cycles.
  - Pulses shorter than FILTER_CYCLES are ignored.
  - Detect latency is 3+FILTER_CYCLES clk; measured widths are unchanged for clean edges, since both edges are delayed equally.
- Undefined: no filter; 3-clk detect latency; every synchronized transition counts.

Test Plan:
- Reset, then 1500 us high / 18500 us low, three periods -> valid strobes with data=1500; after 2nd rise period=20000; error=0, timeout=0.
- Pulse of 149999 cycles high -> data=1499; pulse of 150000 cycles -> data=1500 (floor rule).
- 300 us pulse, then 3000 us pulse, after a prior accepted 1000 us pulse -> two error strobes, no valid, data stays 1000.
- Input held high 30 ms after a rise -> timeout=1 at el_us=25000, state ARM. Then low plus a 1200 us pulse -> valid, data=1200, timeout=0.
- Assert rst for 1 cycle midway through a 2000 us pulse -> all outputs 0; remainder of that pulse ignored; next full 1000 us pulse reported data=1000.
- With GLITCH_FILTER_EN, 50 ns (5-cycle) high glitch during low phase -> no state change, period unaffected. Without the macro, the same glitch -> error strobe (hi_us=0).

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - servo pulse high-time/period decoder
// Optional input glitch filter enabled by defining GLITCH_FILTER_EN.
module servo_pulse_decoder #(
  parameter int CLKS_PER_US   = 100,
  parameter int MIN_PULSE_US  = 500,
  parameter int MAX_PULSE_US  = 2500,
  parameter int TIMEOUT_US    = 25000,
  parameter int FILTER_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signal_in,
  output logic [15:0] data,
  output logic        valid,
  output logic [15:0] period,
  output logic        error,
  output logic        timeout
);

  localparam int            PW       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_US - 1);
  localparam logic [15:0]   MIN_L    = 16'(MIN_PULSE_US);
  localparam logic [15:0]   MAX_L    = 16'(MAX_PULSE_US);
  localparam logic [15:0]   TO_L     = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_e;

  // The input chain is deliberately not reset so it keeps tracking the pin
  // while rst is low; ARM then sees the true level of a pulse in progress.
  logic sync1_q;
  logic sync2_q;
  logic level;
  logic edge_q;

  always_ff @(posedge clk) begin
    sync1_q <= signal_in;
    sync2_q <= sync1_q;
  end

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic [FW-1:0] flt_cnt_q;
  logic          flt_q;
  logic          flt_take;

  assign flt_take = (sync2_q != flt_q) && (flt_cnt_q == FW'(FILTER_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      flt_cnt_q <= '0;
    end else if (sync2_q == flt_q || flt_take) begin
      flt_cnt_q <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flt_take) begin
      flt_q <= sync2_q;
    end
  end

  assign level = flt_q;
`else
  logic [31:0] unused_filter_cycles;
  assign unused_filter_cycles = FILTER_CYCLES;
  assign level = sync2_q;
`endif

  always_ff @(posedge clk) begin
    edge_q <= level;
  end

  logic rise;
  logic fall;
  assign rise = level & ~edge_q;
  assign fall = ~level & edge_q;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   hi_q;
  logic [15:0]   el_q;
  logic [15:0]   data_q;
  logic [15:0]   period_q;
  logic          valid_q;
  logic          error_q;
  logic          timeout_q;

  // Next counter values include this cycle's terminal count, so a pulse of
  // exactly N*CLKS_PER_US cycles is seen as N on its fall-detect cycle.
  logic          tc;
  logic [PW-1:0] presc_d;
  logic [15:0]   hi_d;
  logic [15:0]   el_d;

  always_comb begin
    tc      = (presc_q == PRESC_TC);
    presc_d = tc ? '0 : presc_q + 1'b1;
    hi_d    = (tc && hi_q != 16'hFFFF) ? hi_q + 16'd1 : hi_q;
    el_d    = (tc && el_q != 16'hFFFF) ? el_q + 16'd1 : el_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARM;
      presc_q   <= '0;
      hi_q      <= '0;
      el_q      <= '0;
      data_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      presc_q <= rise ? '0 : presc_d;
      case (state_q)
        ARM: begin
          if (!level) begin
            state_q <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            hi_q    <= '0;
            el_q    <= '0;
            state_q <= HIGH;
          end
        end
        HIGH: begin
          hi_q <= hi_d;
          el_q <= el_d;
          if (fall) begin
            state_q <= LOW;
            if (hi_d >= MIN_L && hi_d <= MAX_L) begin
              data_q    <= hi_d;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end else if (el_d >= TO_L) begin
            timeout_q <= 1'b1;
            state_q   <= ARM;
          end
        end
        LOW: begin
          el_q <= el_d;
          if (rise) begin
            period_q <= el_d;
            hi_q     <= '0;
            el_q     <= '0;
            state_q  <= HIGH;
          end else if (el_d >= TO_L) begin
            timeout_q <= 1'b1;
            state_q   <= WAIT_RISE;
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign period  = period_q;
  assign error   = error_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - randomized bench for servo_pulse_decoder against an interval-level model
module tb_servo_pulse_decoder;

  localparam int C    = 2;
  localparam int MINU = 50;
  localparam int MAXU = 250;
  localparam int TOU  = 2500;
  localparam int FC   = 8;
  localparam int TOC  = TOU * C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signal_in = 1'b0;
  logic [15:0] data;
  logic        valid;
  logic [15:0] period;
  logic        error;
  logic        timeout;

  servo_pulse_decoder #(
    .CLKS_PER_US  (C),
    .MIN_PULSE_US (MINU),
    .MAX_PULSE_US (MAXU),
    .TIMEOUT_US   (TOU),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .signal_in(signal_in),
    .data     (data),
    .valid    (valid),
    .period   (period),
    .error    (error),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Strobe log: accepted width as a value, rejected pulse as -1.
  int got_q[$];
  int exp_q[$];
  int both_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (valid && error) both_seen++;
      if (valid) got_q.push_back(int'(data));
      if (error) got_q.push_back(-1);
    end
  end

  // Model works on whole pin intervals: widths in cycles, floor to us.
  typedef enum {M_ARM, M_WAIT, M_LOW} mst_e;
  mst_e m_st = M_ARM;
  int   m_t = 0;
  int   m_data = 0;
  int   m_period = 0;
  int   m_to = 0;

  function automatic int us_of(input int cyc);
    return (cyc / C > 65535) ? 65535 : cyc / C;
  endfunction

  task automatic model_high(input int d);
    int w;
    if (d > TOC) begin
      m_to = 1;
      m_st = M_ARM;
    end else begin
      w = us_of(d);
      if (w >= MINU && w <= MAXU) begin
        exp_q.push_back(w);
        m_data = w;
        m_to   = 0;
      end else begin
        exp_q.push_back(-1);
      end
      m_t  = d;
      m_st = M_LOW;
    end
  endtask

  task automatic model_seg(input int lvl, input int d);
    case (m_st)
      M_ARM:  if (lvl == 0) m_st = M_WAIT;
      M_WAIT: if (lvl == 1) model_high(d);
      M_LOW: begin
        if (lvl == 1) begin
          m_period = us_of(m_t);
          model_high(d);
        end else begin
          m_t += d;
          if (m_t > TOC) begin
            m_to = 1;
            m_st = M_WAIT;
          end
        end
      end
      default: m_st = M_ARM;
    endcase
  endtask

  task automatic drive(input logic lvl, input int d);
    signal_in = lvl;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int d);
    drive(lvl, d);
    model_seg(int'(lvl), d);
  endtask

  task automatic cp(input string tag);
    check({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".strobe"}, got_q[i], exp_q[i]);
    check({tag, ".data"}, int'(data), m_data);
    check({tag, ".period"}, int'(period), m_period);
    check({tag, ".timeout"}, int'(timeout), m_to);
    check({tag, ".both"}, both_seen, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst.data", int'(data), 0);
    check("rst.valid", int'(valid), 0);
    check("rst.period", int'(period), 0);
    check("rst.error", int'(error), 0);
    check("rst.timeout", int'(timeout), 0);
    rst = 1'b1;
    seg(0, 200);

    for (int i = 0; i < 3; i++) begin
      seg(1, 1500 * C / 10);
      seg(0, 18500 * C / 10);
      cp("nominal");
    end

    seg(1, 299);
    seg(0, 1000);
    cp("floor_below");
    seg(1, 300);
    seg(0, 1000);
    cp("floor_exact");

    seg(1, 100 * C);
    seg(0, 1000);
    cp("accept_100");
    seg(1, 30 * C);
    seg(0, 1000);
    seg(1, 300 * C);
    seg(0, 1000);
    cp("range_err");

    seg(1, 3000 * C);
    cp("stuck_high");
    seg(0, 500);
    seg(1, 120 * C);
    seg(0, 1000);
    cp("recover");

    seg(1, 100 * C);
    seg(0, 3000 * C);
    cp("low_timeout");
    seg(1, 100 * C);
    seg(0, 1000);
    cp("after_low_to");

    drive(1'b1, 400);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_st = M_ARM;
    m_data = 0;
    m_period = 0;
    m_to = 0;
    check("midrst.valid", int'(valid), 0);
    check("midrst.error", int'(error), 0);
    cp("midrst");
    seg(1, 399);
    seg(0, 1000);
    seg(1, 100 * C);
    seg(0, 1000);
    cp("post_rst");

    seg(1, 100 * C);
    seg(0, 1000);
`ifdef GLITCH_FILTER_EN
    drive(1'b1, 5);
    model_seg(0, 5);
`else
    seg(1, 5);
`endif
    seg(0, 1000);
    seg(1, 100 * C);
    seg(0, 500);
    cp("glitch");

    for (int i = 0; i < 12; i++) begin
      seg(1, int'($urandom_range(20 * C, 280 * C)));
      seg(0, int'($urandom_range(100, 750)));
      cp("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
